// File: rtl/sync_sequencer_multi.sv
// -----------------------------------------------------------------------------
// sync_sequencer_multi
// Experiment sequencer: arm -> wait function-generator edge -> programmed delay
// -> detonation pulse -> wait wire-break edge (optional timeout) -> DET_CH
// detector pulses at individually programmed delays after the wire edge.
//
// Ports
//   CLOCK_50           system clock
//   reset_n            asynchronous reset, active low
//   start_signal       arm request (async, rising edge)
//   abort_signal       abort (async, synchronised level)
//   fg_signal          function-generator trigger (async, rising edge)
//   wire_signal        wire-break trigger (async, rising edge)
//   fg_delay           clocks from fg edge to detonation, latched at arm
//   det_delay          per-channel clocks from wire edge, ch i = [i*CNT_W +: CNT_W]
//   detonation_signal  detonation pulse, PULSE_W clocks
//   detector_signal    detector pulses, PULSE_W clocks each
//   busy               high whenever the sequencer is not idle
//   done               one-clock pulse on normal completion
//   timeout_err        sticky wire-timeout flag, cleared by the next accepted arm
//   state_out          current state encoding
// -----------------------------------------------------------------------------
module sync_sequencer_multi #(
    parameter int CNT_W        = 32,
    parameter int DET_CH       = 4,
    parameter int PULSE_W      = 5,
    parameter int WIRE_TIMEOUT = 350_000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    start_signal,
    input  logic                    abort_signal,
    input  logic                    fg_signal,
    input  logic                    wire_signal,
    input  logic [CNT_W-1:0]        fg_delay,
    input  logic [DET_CH*CNT_W-1:0] det_delay,
    output logic                    detonation_signal,
    output logic [DET_CH-1:0]       detector_signal,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [2:0]              state_out
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FG_WAIT  = 3'd1,
        ST_FG_DLY   = 3'd2,
        ST_DETONATE = 3'd3,
        ST_WIRE_WAIT= 3'd4,
        ST_DET_RUN  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam int               PW_W         = $clog2(PULSE_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_W);
    localparam logic [PW_W-1:0]  PC_LAST      = PW_W'(PULSE_W);
    // Counter value in the last WIRE_WAIT cycle before the timeout fires.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (WIRE_TIMEOUT == 0) ? '0 : CNT_W'(WIRE_TIMEOUT - 1);

    state_t                  state_r, next_state_s;
    logic [3:0]              sync_r [SYNC_STAGES];
    logic [3:0]              sync_d1_r;
    logic [3:0]              in_s, sync_s, edge_s;
    logic                    start_edge_s, abort_lvl_s, fg_edge_s, wire_edge_s;
    logic                    timeout_hit_s, cnt_is_max_s;

    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [CNT_W-1:0]        fg_delay_r, fg_delay_nxt_s;
    logic [CNT_W-1:0]        det_delay_r [DET_CH];
    logic [CNT_W-1:0]        det_delay_nxt_s [DET_CH];
    logic [PW_W-1:0]         pc_r [DET_CH];
    logic [PW_W-1:0]         pc_nxt_s [DET_CH];
    logic [DET_CH-1:0]       fired_r, fired_nxt_s;
    logic [DET_CH-1:0]       detect_r, detect_nxt_s;
    logic                    deton_r, deton_nxt_s;
    logic                    terr_r, terr_nxt_s;
    logic                    busy_r, done_r;

    assign in_s          = {wire_signal, fg_signal, abort_signal, start_signal};
    assign sync_s        = sync_r[SYNC_STAGES-1];
    assign edge_s        = sync_s & ~sync_d1_r;
    assign start_edge_s  = edge_s[0];
    assign abort_lvl_s   = sync_s[1];
    assign fg_edge_s     = edge_s[2];
    assign wire_edge_s   = edge_s[3];
    assign cnt_is_max_s  = (cnt_r == CNT_MAX);
    assign cnt_inc_s     = cnt_is_max_s ? cnt_r : (cnt_r + CNT_W'(1));
    assign timeout_hit_s = (WIRE_TIMEOUT != 0) && (cnt_r == TIMEOUT_LAST);

    // Input synchroniser chains plus the delayed copy used for edge detection.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 4'd0;
            sync_d1_r <= 4'd0;
        end else begin
            sync_r[0] <= in_s;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            sync_d1_r <= sync_s;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= next_state_s;
    end

    // FSM next-state logic; abort overrides every non-idle transition.
    always_comb begin
        next_state_s = state_r;
        if ((state_r != ST_IDLE) && abort_lvl_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:      if (start_edge_s) next_state_s = ST_FG_WAIT;
                              else              next_state_s = ST_IDLE;
                // A zero fg delay skips FG_DLY so detonation starts right after the edge cycle.
                ST_FG_WAIT:   if (fg_edge_s) next_state_s = (fg_delay_r == '0) ? ST_DETONATE : ST_FG_DLY;
                              else           next_state_s = ST_FG_WAIT;
                ST_FG_DLY:    if (cnt_r == fg_delay_r) next_state_s = ST_DETONATE;
                              else                     next_state_s = ST_FG_DLY;
                ST_DETONATE:  if (cnt_r == PULSE_LAST) next_state_s = ST_WIRE_WAIT;
                              else                     next_state_s = ST_DETONATE;
                ST_WIRE_WAIT: if (wire_edge_s)        next_state_s = ST_DET_RUN;
                              else if (timeout_hit_s) next_state_s = ST_IDLE;
                              else                    next_state_s = ST_WIRE_WAIT;
                ST_DET_RUN:   if ((&fired_r) && (detect_r == '0)) next_state_s = ST_DONE;
                              else                                 next_state_s = ST_DET_RUN;
                ST_DONE:      next_state_s = ST_IDLE;
                default:      next_state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath/output next values. The shared counter holds "clocks since the
    // triggering edge cycle", so a pulse is launched at the end of the cycle
    // where counter == delay and is visible delay+1 clocks after the edge.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        fg_delay_nxt_s  = fg_delay_r;
        det_delay_nxt_s = det_delay_r;
        pc_nxt_s        = pc_r;
        fired_nxt_s     = fired_r;
        detect_nxt_s    = detect_r;
        deton_nxt_s     = deton_r;
        terr_nxt_s      = terr_r;
        if ((state_r != ST_IDLE) && abort_lvl_s) begin
            deton_nxt_s  = 1'b0;
            detect_nxt_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s && !abort_lvl_s) begin
                        fg_delay_nxt_s = fg_delay;
                        for (int i = 0; i < DET_CH; i++) det_delay_nxt_s[i] = det_delay[i*CNT_W +: CNT_W];
                        terr_nxt_s  = 1'b0;
                        cnt_nxt_s   = '0;
                        fired_nxt_s = '0;
                    end else begin
                        cnt_nxt_s = '0;
                    end
                end
                ST_FG_WAIT: begin
                    // Counter starts at 1: the cycle after the edge is clock 1.
                    if (fg_edge_s) begin
                        cnt_nxt_s   = CNT_W'(1);
                        deton_nxt_s = (fg_delay_r == '0);
                    end else begin
                        cnt_nxt_s = '0;
                    end
                end
                ST_FG_DLY: begin
                    if (cnt_r == fg_delay_r) begin
                        deton_nxt_s = 1'b1;
                        cnt_nxt_s   = CNT_W'(1);
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                ST_DETONATE: begin
                    // Counter doubles as the detonation pulse-length counter here.
                    if (cnt_r == PULSE_LAST) begin
                        deton_nxt_s = 1'b0;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                ST_WIRE_WAIT: begin
                    if (wire_edge_s) begin
                        cnt_nxt_s = CNT_W'(1);
                        for (int i = 0; i < DET_CH; i++) begin
                            if (det_delay_r[i] == '0) begin
                                detect_nxt_s[i] = 1'b1;
                                pc_nxt_s[i]     = PW_W'(1);
                                fired_nxt_s[i]  = 1'b1;
                            end else begin
                                detect_nxt_s[i] = 1'b0;
                            end
                        end
                    end else if (timeout_hit_s) begin
                        terr_nxt_s = 1'b1;
                        cnt_nxt_s  = '0;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                ST_DET_RUN: begin
                    cnt_nxt_s = cnt_inc_s;
                    // fired_r keeps a saturated counter from retriggering a channel.
                    for (int i = 0; i < DET_CH; i++) begin
                        if (detect_r[i]) begin
                            if (pc_r[i] == PC_LAST) detect_nxt_s[i] = 1'b0;
                            else                    pc_nxt_s[i]     = pc_r[i] + PW_W'(1);
                        end else if (!fired_r[i] && (cnt_r == det_delay_r[i])) begin
                            detect_nxt_s[i] = 1'b1;
                            pc_nxt_s[i]     = PW_W'(1);
                            fired_nxt_s[i]  = 1'b1;
                        end else begin
                            detect_nxt_s[i] = 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    cnt_nxt_s = '0;
                end
                default: begin
                    cnt_nxt_s    = '0;
                    deton_nxt_s  = 1'b0;
                    detect_nxt_s = '0;
                end
            endcase
        end
    end

    // Datapath and registered-output flops.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r      <= '0;
            fg_delay_r <= '0;
            for (int i = 0; i < DET_CH; i++) begin
                det_delay_r[i] <= '0;
                pc_r[i]        <= '0;
            end
            fired_r  <= '0;
            detect_r <= '0;
            deton_r  <= 1'b0;
            terr_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            fg_delay_r  <= fg_delay_nxt_s;
            det_delay_r <= det_delay_nxt_s;
            pc_r        <= pc_nxt_s;
            fired_r     <= fired_nxt_s;
            detect_r    <= detect_nxt_s;
            deton_r     <= deton_nxt_s;
            terr_r      <= terr_nxt_s;
            busy_r      <= (next_state_s != ST_IDLE);
            done_r      <= (next_state_s == ST_DONE);
        end
    end

    assign detonation_signal = deton_r;
    assign detector_signal   = detect_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign timeout_err       = terr_r;
    assign state_out         = state_r;

endmodule

// File: tb/tb_sync_sequencer_multi.sv
// Directed bench for sync_sequencer_multi. dut_a: PULSE_W=5, WIRE_TIMEOUT=100.
// dut_b: PULSE_W=1, no timeout, used for the zero-delay corner.
module tb_sync_sequencer_multi;

    localparam int SYNC = 2;
    localparam int PW_A = 5;
    localparam int TO_A = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, abort_a = 1'b0, fg_a = 1'b0, wire_a = 1'b0;
    logic [31:0] fg_delay_a = 32'd0;
    logic [127:0] det_delay_a = 128'd0;
    logic        a_deton, a_busy, a_done, a_terr;
    logic [3:0]  a_detect;
    logic [2:0]  a_state;

    logic        start_b = 1'b0, abort_b = 1'b0, fg_b = 1'b0, wire_b = 1'b0;
    logic [31:0] fg_delay_b = 32'd0;
    logic [127:0] det_delay_b = 128'd0;
    logic        b_deton, b_busy, b_done, b_terr;
    logic [3:0]  b_detect;
    logic [2:0]  b_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int deton_rise, deton_rises, deton_len, terr_rise, done_cnt;
    int det_rise [4];
    int det_rises [4];
    int det_len [4];
    logic deton_prev = 1'b0, terr_prev = 1'b0;
    logic [3:0] det_prev = 4'd0;
    int c_fg, c_w, b_done_cnt;

    always #10 clk = ~clk;

    sync_sequencer_multi #(.CNT_W(32), .DET_CH(4), .PULSE_W(PW_A), .WIRE_TIMEOUT(TO_A), .SYNC_STAGES(SYNC)) dut_a (
        .CLOCK_50(clk), .reset_n(rst_n), .start_signal(start_a), .abort_signal(abort_a),
        .fg_signal(fg_a), .wire_signal(wire_a), .fg_delay(fg_delay_a), .det_delay(det_delay_a),
        .detonation_signal(a_deton), .detector_signal(a_detect), .busy(a_busy), .done(a_done),
        .timeout_err(a_terr), .state_out(a_state));

    sync_sequencer_multi #(.CNT_W(32), .DET_CH(4), .PULSE_W(1), .WIRE_TIMEOUT(0), .SYNC_STAGES(SYNC)) dut_b (
        .CLOCK_50(clk), .reset_n(rst_n), .start_signal(start_b), .abort_signal(abort_b),
        .fg_signal(fg_b), .wire_signal(wire_b), .fg_delay(fg_delay_b), .det_delay(det_delay_b),
        .detonation_signal(b_deton), .detector_signal(b_detect), .busy(b_busy), .done(b_done),
        .timeout_err(b_terr), .state_out(b_state));

    task automatic check_value(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample #1 after the edge, and update dut_a pulse statistics.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (a_deton && !deton_prev) begin deton_rise = cyc; deton_rises++; end
        if (a_deton) deton_len++;
        for (int i = 0; i < 4; i++) begin
            if (a_detect[i] && !det_prev[i]) begin det_rise[i] = cyc; det_rises[i]++; end
            if (a_detect[i]) det_len[i]++;
        end
        if (a_terr && !terr_prev) terr_rise = cyc;
        if (a_done) done_cnt++;
        deton_prev = a_deton;
        det_prev   = a_detect;
        terr_prev  = a_terr;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr_stats();
        deton_rise = -1; deton_rises = 0; deton_len = 0; terr_rise = -1; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin det_rise[i] = -1; det_rises[i] = 0; det_len[i] = 0; end
    endtask

    task automatic arm_a();
        start_a = 1'b1; ticks(3); start_a = 1'b0; ticks(2);
    endtask

    task automatic fg_pulse_a();
        c_fg = cyc; fg_a = 1'b1; ticks(3); fg_a = 1'b0;
    endtask

    task automatic wire_pulse_a();
        c_w = cyc; wire_a = 1'b1; ticks(3); wire_a = 1'b0;
    endtask

    initial begin
        clr_stats();
        // ---- reset state
        #25;
        check_value("rst_deton", a_deton, 0);
        check_value("rst_detect", a_detect, 0);
        check_value("rst_busy", a_busy, 0);
        check_value("rst_done", a_done, 0);
        check_value("rst_terr", a_terr, 0);
        check_value("rst_state", a_state, 0);
        #10 rst_n = 1'b1;
        ticks(3);

        // ---- test 1: nominal run
        clr_stats();
        fg_delay_a  = 32'd10;
        det_delay_a = {32'd7, 32'd7, 32'd0, 32'd3};
        arm_a();
        check_value("t1_state_fgwait", a_state, 1);
        check_value("t1_busy", a_busy, 1);
        fg_pulse_a();
        ticks(30);
        check_value("t1_deton_rise", deton_rise, c_fg + SYNC + 10 + 1);
        check_value("t1_deton_len", deton_len, PW_A);
        check_value("t1_state_wirewait", a_state, 4);
        wire_pulse_a();
        ticks(30);
        check_value("t1_ch0_rise", det_rise[0], c_w + SYNC + 3 + 1);
        check_value("t1_ch1_rise", det_rise[1], c_w + SYNC + 0 + 1);
        check_value("t1_ch2_rise", det_rise[2], c_w + SYNC + 7 + 1);
        check_value("t1_ch3_rise", det_rise[3], c_w + SYNC + 7 + 1);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("t1_ch%0d_len", i), det_len[i], PW_A);
            check_value($sformatf("t1_ch%0d_fires", i), det_rises[i], 1);
        end
        check_value("t1_done_cnt", done_cnt, 1);
        check_value("t1_state_end", a_state, 0);

        // ---- test 2: wire timeout
        clr_stats();
        fg_delay_a = 32'd2;
        arm_a();
        fg_pulse_a();
        ticks(130);
        check_value("t2_terr_rise", terr_rise, c_fg + SYNC + 2 + 1 + PW_A + TO_A);
        check_value("t2_terr", a_terr, 1);
        check_value("t2_state", a_state, 0);
        check_value("t2_done_cnt", done_cnt, 0);
        arm_a();
        check_value("t2_terr_cleared", a_terr, 0);
        check_value("t2_rearm_state", a_state, 1);
        abort_a = 1'b1; ticks(4);
        check_value("t2_abort_idle", a_state, 0);
        abort_a = 1'b0; ticks(2);

        // ---- test 3: abort during DET_RUN with ch0 high
        clr_stats();
        fg_delay_a  = 32'd1;
        det_delay_a = {32'd7, 32'd7, 32'd0, 32'd3};
        arm_a();
        fg_pulse_a();
        ticks(20);
        wire_pulse_a();
        for (int k = 0; k < 20 && !a_detect[0]; k++) tick();
        check_value("t3_ch0_up", a_detect[0], 1);
        abort_a = 1'b1;
        ticks(2);
        check_value("t3_still_run", a_state, 5);
        tick();
        check_value("t3_detect_off", a_detect, 0);
        check_value("t3_deton_off", a_deton, 0);
        check_value("t3_state", a_state, 0);
        check_value("t3_busy", a_busy, 0);
        abort_a = 1'b0;
        ticks(15);
        check_value("t3_no_done", done_cnt, 0);
        check_value("t3_ch2_never", det_rises[2], 0);

        // ---- test 4: start ignored while busy, delays latched at arm
        clr_stats();
        fg_delay_a  = 32'd10;
        det_delay_a = {32'd7, 32'd7, 32'd0, 32'd3};
        arm_a();
        fg_delay_a  = 32'd20;
        det_delay_a = {32'd9, 32'd9, 32'd9, 32'd9};
        fg_pulse_a();
        ticks(3);
        start_a = 1'b1; ticks(3); start_a = 1'b0;
        ticks(20);
        check_value("t4_deton_rise", deton_rise, c_fg + SYNC + 10 + 1);
        check_value("t4_state_wirewait", a_state, 4);
        wire_pulse_a();
        ticks(3);
        start_a = 1'b1; ticks(3); start_a = 1'b0;
        ticks(25);
        check_value("t4_ch1_rise", det_rise[1], c_w + SYNC + 0 + 1);
        check_value("t4_ch2_rise", det_rise[2], c_w + SYNC + 7 + 1);
        check_value("t4_done_cnt", done_cnt, 1);
        check_value("t4_state_idle", a_state, 0);

        // ---- test 5: asynchronous / glitchy inputs, reset mid-detonation
        clr_stats();
        fg_delay_a  = 32'd3;
        det_delay_a = {32'd7, 32'd7, 32'd0, 32'd3};
        arm_a();
        #2 fg_a = 1'b1; #3 fg_a = 1'b0;
        tick();
        #6 fg_a = 1'b1;
        c_fg = cyc;
        ticks(3);
        #4 fg_a = 1'b0;
        ticks(15);
        check_value("t5_deton_once", deton_rises, 1);
        check_value("t5_deton_rise", deton_rise, c_fg + SYNC + 3 + 1);
        #2 wire_a = 1'b1; #3 wire_a = 1'b0;
        tick();
        #6 wire_a = 1'b1;
        c_w = cyc;
        ticks(3);
        #4 wire_a = 1'b0;
        ticks(25);
        for (int i = 0; i < 4; i++) check_value($sformatf("t5_ch%0d_once", i), det_rises[i], 1);
        check_value("t5_ch1_rise", det_rise[1], c_w + SYNC + 0 + 1);
        check_value("t5_done_cnt", done_cnt, 1);
        arm_a();
        fg_pulse_a();
        for (int k = 0; k < 20 && !a_deton; k++) tick();
        check_value("t5_deton_seen", a_deton, 1);
        #5 rst_n = 1'b0;
        #1;
        check_value("t5_rst_deton", a_deton, 0);
        check_value("t5_rst_state", a_state, 0);
        check_value("t5_rst_busy", a_busy, 0);
        #4 rst_n = 1'b1;
        ticks(3);
        check_value("t5_post_rst_idle", a_state, 0);

        // ---- test 6: zero delays, PULSE_W=1 (dut_b)
        start_b = 1'b1; ticks(3); start_b = 1'b0; ticks(2);
        check_value("t6_state_fgwait", b_state, 1);
        fg_b = 1'b1;
        ticks(2);
        check_value("t6_deton_pre", b_deton, 0);
        tick();
        fg_b = 1'b0;
        check_value("t6_deton_on", b_deton, 1);
        tick();
        check_value("t6_deton_off", b_deton, 0);
        ticks(2);
        check_value("t6_state_wirewait", b_state, 4);
        wire_b = 1'b1;
        ticks(2);
        check_value("t6_detect_pre", b_detect, 0);
        tick();
        wire_b = 1'b0;
        check_value("t6_detect_all", b_detect, 4'hF);
        tick();
        check_value("t6_detect_off", b_detect, 0);
        b_done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (b_done) b_done_cnt++;
            tick();
        end
        check_value("t6_done_cnt", b_done_cnt, 1);
        check_value("t6_state_idle", b_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
